// File: rtl/pcie_pipe_pkg.sv
// Shared types and helpers for the PIPE rate/PCLK-change sequencer.
package pcie_pipe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EI,
        RATE,
        WAIT_OK,
        WAIT_PHY
    } state_t;

    // PIPE width encodings as driven on the width output
    localparam logic [1:0] W8  = 2'd0;
    localparam logic [1:0] W16 = 2'd1;
    localparam logic [1:0] W32 = 2'd2;

    // Data width in bits -> width encoding; anything unexpected falls back to 8b
    function automatic logic [1:0] width_enc(input int bits);
        case (bits)
            16:      return W16;
            32:      return W32;
            default: return W8;
        endcase
    endfunction

    // Generation -> width encoding using the per-generation PIPE widths
    function automatic logic [1:0] gen_width(input logic [2:0] gen,
                                             input int w1, input int w2,
                                             input int w3, input int w4,
                                             input int w5);
        case (gen)
            3'd2:    return width_enc(w2);
            3'd3:    return width_enc(w3);
            3'd4:    return width_enc(w4);
            3'd5:    return width_enc(w5);
            default: return width_enc(w1);
        endcase
    endfunction

endpackage

// File: rtl/pipe_rate_ctrl_if.sv
// LTSSM request/response and PIPE command/status bundle for pipe_rate_ctrl.
interface pipe_rate_ctrl_if #(
    parameter int LANESNUMBER = 16
);
    logic                   req_valid;
    logic [2:0]             req_gen;
    logic                   req_ready;
    logic                   done;
    logic                   err;
    logic                   busy;
    logic [2:0]             cur_gen;
    logic                   force_elecidle;
    logic [3:0]             Rate;
    logic [4:0]             PCLKRate;
    logic [1:0]             width;
    logic                   PclkChangeOk;
    logic                   PclkChangeAck;
    logic [LANESNUMBER-1:0] PhyStatus;

    // LTSSM + PHY side: drives requests and PHY status
    modport master (
        output req_valid, req_gen, PclkChangeOk, PhyStatus,
        input  req_ready, done, err, busy, cur_gen, force_elecidle,
               Rate, PCLKRate, width, PclkChangeAck
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_gen, PclkChangeOk, PhyStatus,
        output req_ready, done, err, busy, cur_gen, force_elecidle,
               Rate, PCLKRate, width, PclkChangeAck
    );
endinterface

// File: rtl/pipe_phystatus_collect.sv
// Sticky per-lane PhyStatus collector: ORs pulses into a mask until cleared.
module pipe_phystatus_collect #(
    parameter int LANESNUMBER = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clr,
    input  logic                   i_en,
    input  logic [LANESNUMBER-1:0] i_status,
    output logic                   o_all_seen
);
    logic [LANESNUMBER-1:0] r_mask;
    logic [LANESNUMBER-1:0] w_merged;

    // Include this cycle's pulses so completion is seen on the cycle the last lane reports
    assign w_merged   = r_mask | i_status;
    assign o_all_seen = i_en & (&w_merged);

    // Accumulate lane pulses while enabled; clear takes priority
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_mask <= '0;
        else if (i_clr)
            r_mask <= '0;
        else if (i_en)
            r_mask <= w_merged;
    end
endmodule

// File: rtl/pipe_rate_ctrl.sv
// PIPE rate / PCLK-change sequencer between the LTSSM and the PHY.
module pipe_rate_ctrl
    import pcie_pipe_pkg::*;
#(
    parameter int LANESNUMBER     = 16,
    parameter int MAX_GEN         = 5,
    parameter int GEN1_PIPEWIDTH  = 8,
    parameter int GEN2_PIPEWIDTH  = 8,
    parameter int GEN3_PIPEWIDTH  = 8,
    parameter int GEN4_PIPEWIDTH  = 8,
    parameter int GEN5_PIPEWIDTH  = 8,
    parameter int EI_SETTLE       = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic           CLK,
    input  logic           reset,
    pipe_rate_ctrl_if.slave bus
);
    // One counter serves both the EI settle hold and the handshake watchdog
    localparam int CMAX = (TIMEOUT_CYCLES > EI_SETTLE) ? TIMEOUT_CYCLES : EI_SETTLE;
    localparam int CW   = $clog2(CMAX) + 1;

    state_t          r_state, w_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_n;
    logic [2:0]      r_tgt, r_cur_gen;
    logic            r_done, r_err, r_ack, r_fei, r_busy, r_ready;
    logic [3:0]      r_rate;
    logic [4:0]      r_pclk;
    logic [1:0]      r_width;

    logic            w_done_n, w_err_n, w_ack_n, w_fei_n;
    logic            w_load, w_commit, w_clr;
    logic            w_gen_bad, w_same, w_ei_done, w_tmo, w_all_seen;
    logic [2:0]      w_tgt_m1;

    assign w_gen_bad = (bus.req_gen == 3'd0) || (int'(bus.req_gen) > MAX_GEN);
    assign w_same    = (bus.req_gen == r_cur_gen);
    assign w_ei_done = (r_cnt == CW'(EI_SETTLE - 1));
    assign w_tmo     = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign w_tgt_m1  = r_tgt - 3'd1;

    pipe_phystatus_collect #(.LANESNUMBER(LANESNUMBER)) u_collect (
        .i_clk      (CLK),
        .i_rst_n    (reset),
        .i_clr      (w_clr),
        .i_en       (r_state == WAIT_PHY),
        .i_status   (bus.PhyStatus),
        .o_all_seen (w_all_seen)
    );

    // State register
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_nxt;
    end

    // Next-state logic; completion is checked before the watchdog so it wins a tie
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:     if (bus.req_valid && !w_gen_bad && !w_same) w_nxt = EI;
            EI:       if (w_ei_done) w_nxt = RATE;
            RATE:     w_nxt = WAIT_OK;
            WAIT_OK:  if (bus.PclkChangeOk) w_nxt = WAIT_PHY;
                      else if (w_tmo)       w_nxt = IDLE;
            WAIT_PHY: if (w_all_seen || w_tmo) w_nxt = IDLE;
            default:  w_nxt = IDLE;
        endcase
    end

    // Next values for the registered outputs and counter
    always_comb begin
        w_done_n = 1'b0;
        w_err_n  = 1'b0;
        w_ack_n  = r_ack;
        w_fei_n  = r_fei;
        w_load   = 1'b0;
        w_commit = 1'b0;
        w_clr    = 1'b0;
        w_cnt_n  = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (w_gen_bad)   w_err_n  = 1'b1;
                    else if (w_same) w_done_n = 1'b1;
                    else begin
                        w_fei_n = 1'b1;
                        w_cnt_n = '0;
                    end
                end
            end
            EI:   w_cnt_n = w_ei_done ? '0 : r_cnt + CW'(1);
            RATE: begin
                w_load  = 1'b1;
                w_cnt_n = '0;
            end
            WAIT_OK: begin
                if (bus.PclkChangeOk) begin
                    w_ack_n = 1'b1;
                    w_clr   = 1'b1;
                    w_cnt_n = '0;
                end else if (w_tmo) begin
                    w_err_n = 1'b1;
                    w_ack_n = 1'b0;
                    w_fei_n = 1'b0;
                    w_cnt_n = '0;
                end else
                    w_cnt_n = r_cnt + CW'(1);
            end
            WAIT_PHY: begin
                if (w_all_seen) begin
                    w_done_n = 1'b1;
                    w_commit = 1'b1;
                    w_ack_n  = 1'b0;
                    w_fei_n  = 1'b0;
                    w_cnt_n  = '0;
                end else if (w_tmo) begin
                    w_err_n = 1'b1;
                    w_ack_n = 1'b0;
                    w_fei_n = 1'b0;
                    w_cnt_n = '0;
                end else
                    w_cnt_n = r_cnt + CW'(1);
            end
            default: begin
                w_ack_n = 1'b0;
                w_fei_n = 1'b0;
                w_cnt_n = '0;
            end
        endcase
    end

    // Output and datapath registers; Rate/width survive a timeout, cur_gen only moves on success
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_tgt     <= 3'd1;
            r_cur_gen <= 3'd1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_ack     <= 1'b0;
            r_fei     <= 1'b0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
            r_rate    <= 4'd0;
            r_pclk    <= 5'd0;
            r_width   <= width_enc(GEN1_PIPEWIDTH);
        end else begin
            r_cnt   <= w_cnt_n;
            r_done  <= w_done_n;
            r_err   <= w_err_n;
            r_ack   <= w_ack_n;
            r_fei   <= w_fei_n;
            r_busy  <= (w_nxt != IDLE);
            r_ready <= (w_nxt == IDLE);
            if (r_state == IDLE && w_nxt == EI)
                r_tgt <= bus.req_gen;
            if (w_load) begin
                r_rate  <= {1'b0, w_tgt_m1};
                r_pclk  <= {2'b00, w_tgt_m1};
                r_width <= gen_width(r_tgt, GEN1_PIPEWIDTH, GEN2_PIPEWIDTH,
                                     GEN3_PIPEWIDTH, GEN4_PIPEWIDTH, GEN5_PIPEWIDTH);
            end
            if (w_commit)
                r_cur_gen <= r_tgt;
        end
    end

    assign bus.req_ready      = r_ready;
    assign bus.done           = r_done;
    assign bus.err            = r_err;
    assign bus.busy           = r_busy;
    assign bus.cur_gen        = r_cur_gen;
    assign bus.force_elecidle = r_fei;
    assign bus.Rate           = r_rate;
    assign bus.PCLKRate       = r_pclk;
    assign bus.width          = r_width;
    assign bus.PclkChangeAck  = r_ack;
endmodule
